serial_subtractor_ctrl: RTL and testbench

Bit-serial multi-bit subtractor controller. It computes `a - b - bin` over `WIDTH` bits by sequencing one `full_subtractor` cell, one bit per clock, LSB first. A `start`/`busy`/`done` handshake sits in front of the cell. It is the sequencing layer that turns the single-bit subtractor cell into a usable word-wide arithmetic unit at the cost of `WIDTH` cycles.

---
 rtl/serial_subtractor_ctrl_pkg.sv | 17 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor_ctrl_defs.sv | 8 +
 rtl/serial_subtractor_ctrl.sv | 115 +++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// Types and constants shared by the serial subtractor controller.
`ifndef SERIAL_SUBTRACTOR_CTRL_DEFS_SV
`include "serial_subtractor_ctrl_defs.sv"
`endif

package serial_subtractor_ctrl_pkg;

  localparam int unsigned STATE_W       = 2;
  localparam int unsigned DEFAULT_WIDTH = `SSC_DEFAULT_WIDTH;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = `SSC_ST_IDLE,
    ST_RUN  = `SSC_ST_RUN,
    ST_DONE = `SSC_ST_DONE
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bi, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor_ctrl_defs.sv
// Shared encodings for the serial subtractor controller: FSM state codes and default operand width.
`ifndef SERIAL_SUBTRACTOR_CTRL_DEFS_SV
`define SERIAL_SUBTRACTOR_CTRL_DEFS_SV
`define SSC_ST_IDLE 2'd0
`define SSC_ST_RUN 2'd1
`define SSC_ST_DONE 2'd2
`define SSC_DEFAULT_WIDTH 8
`endif

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin over WIDTH bits, LSB first, through one full_subtractor cell,
// with a start/ready/busy/done handshake.
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             cell_d, cell_bo;
  logic             accept, last_bit;
  logic             ready_d, busy_d, done_d;

  assign accept   = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  full_subtractor u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (brw),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // State and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready   <= ready_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs follow the next state so they are flop outputs aligned with state_q
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      ST_IDLE: ready_d = 1'b1;
      ST_RUN:  busy_d  = 1'b1;
      ST_DONE: begin
        ready_d = 1'b1;
        done_d  = 1'b1;
      end
      default: ready_d = 1'b1;
    endcase
  end

  // Serial datapath; results commit only on the final bit so they hold through the next run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      cnt     <= '0;
      brw     <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      brw  <= bin;
      cnt  <= '0;
    end else if (state_q == ST_RUN) begin
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      diff_sh <= {cell_d, diff_sh[WIDTH-1:1]};
      brw     <= cell_bo;
      if (last_bit) begin
        diff <= {cell_d, diff_sh[WIDTH-1:1]};
        bout <= cell_bo;
        ovf  <= brw ^ cell_bo;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl at WIDTH=8 plus an exhaustive sweep at WIDTH=4.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, bin8, ready8, busy8, done8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, ready4, busy4, done4, bout4, ovf4;
  logic [3:0] a4, b4, diff4;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .ready(ready4), .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle8(input string tag, input logic [7:0] ed, input logic eb, input logic eo);
    chk({tag, "_ready"}, 32'(ready8), 32'd1);
    chk({tag, "_busy"},  32'(busy8),  32'd0);
    chk({tag, "_done"},  32'(done8),  32'd0);
    chk({tag, "_res"},   {22'd0, ovf8, bout8, diff8}, {22'd0, eo, eb, ed});
  endtask

  // Runs one WIDTH=8 operation from IDLE; operands scrambled during RUN must not matter
  task automatic op8(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                     input logic [7:0] ed, input logic eb, input logic eo);
    int cyc, nb;
    start8 = 1'b1; a8 = va; b8 = vb; bin8 = vbin;
    tick();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    cyc = 0; nb = 0;
    while (!done8 && cyc < 20) begin
      if (busy8) nb++;
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd8);
    chk({tag, "_busycnt"}, 32'(nb), 32'd8);
    chk({tag, "_res"}, {22'd0, ovf8, bout8, diff8}, {22'd0, eo, eb, ed});
    chk({tag, "_donerdy"}, {30'd0, ready8, busy8}, 32'b10);
    tick();
    chk_idle8({tag, "_after"}, ed, eb, eo);
  endtask

  task automatic op4(input logic [3:0] va, input logic [3:0] vb, input logic vbin,
                     input logic [5:0] exp_res);
    int cyc;
    start4 = 1'b1; a4 = va; b4 = vb; bin4 = vbin;
    tick();
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 12) begin
      tick();
      cyc++;
    end
    chk($sformatf("w4_%0h_%0h_%0d", va, vb, vbin), {26'd0, ovf4, bout4, diff4}, {26'd0, exp_res});
    tick();
  endtask

  initial begin
    int cyc, r, sa, sb, sr;
    logic [5:0] e4;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    #12;
    chk_idle8("reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    op8("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    op8("v03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    op8("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    op8("v7F_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    op8("v00_00b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

    // start pulsed during RUN is ignored
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
    tick();
    start8 = 1'b0;
    tick(); tick();
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("ign_busy", 32'(busy8), 32'd1);
    cyc = 3;
    while (!done8 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("ign_latency", 32'(cyc), 32'd8);
    chk("ign_res", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b0, 1'b0, 8'h0F});
    tick();
    chk_idle8("ign_after", 8'h0F, 1'b0, 1'b0);

    // back-to-back: start held in DONE skips IDLE
    start8 = 1'b1; a8 = 8'h20; b8 = 8'h02; bin8 = 1'b0;
    tick();
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("b2b_first", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b0, 1'b0, 8'h1E});
    start8 = 1'b1; a8 = 8'h40; b8 = 8'h41; bin8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("b2b_norun_gap", {30'd0, ready8, busy8}, 32'b01);
    chk("b2b_hold", 32'(diff8), 32'h1E);
    cyc = 0;
    while (!done8 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("b2b_latency", 32'(cyc), 32'd8);
    chk("b2b_second", {22'd0, ovf8, bout8, diff8}, {22'd0, 1'b0, 1'b1, 8'hFE});
    tick();

    // asynchronous reset after 4 RUN cycles
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle8("rst_mid", 8'h00, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done8) cyc++;
    end
    chk("rst_nodone", 32'(cyc), 32'd0);
    chk_idle8("rst_idle", 8'h00, 1'b0, 1'b0);
    op8("post_rst", 8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0);

    // exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          r  = ia - ib - ic;
          sa = (ia >= 8) ? ia - 16 : ia;
          sb = (ib >= 8) ? ib - 16 : ib;
          sr = sa - sb - ic;
          e4[3:0] = 4'(r);
          e4[4]   = (r < 0);
          e4[5]   = (sr < -8) || (sr > 7);
          op4(4'(ia), 4'(ib), 1'(ic), e4);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
